alu_exec_ctrl: RTL and testbench

- Execute-stage sequencer for the 8-bit CPU: the driving side of the combinational ALU interface.
- Accepts one decoded instruction per handshake and reads two operands from an internal register file.
- Drives alu_op/r0_data/r1_data to the ALU and samples its o_data/B_PCSrc.
- On branch, updates the PC; otherwise writes the result back to the register file. Then signals retire.

---
 rtl/alu_exec_ctrl_if.sv | 33 +++
 rtl/alu_exec_ctrl.sv | 138 +++++++++++++
 tb/tb_alu_exec_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl_if
// Purpose  : Instruction handshake and ALU operand/result bundle for the
//            execute-stage sequencer. master = sequencer, slave = environment.
// Revision : 1.0
// ============================================================================
interface alu_exec_ctrl_if #(
    parameter int NUM_REGS = 4
);
    localparam int RAW = $clog2(NUM_REGS);
    localparam int IW  = 13 + 3 * RAW;

    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr;
    logic [6:0]    alu_op;
    logic [7:0]    r0_data;
    logic [7:0]    r1_data;
    logic [7:0]    alu_o_data;
    logic          alu_b_pcsrc;

    modport master (
        input  instr_valid, instr, alu_o_data, alu_b_pcsrc,
        output instr_ready, alu_op, r0_data, r1_data
    );

    modport slave (
        output instr_valid, instr, alu_o_data, alu_b_pcsrc,
        input  instr_ready, alu_op, r0_data, r1_data
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl
// Purpose  : Execute-stage sequencer: IDLE -> EXEC -> WB, drives the ALU,
//            writes back or branches. Option macro: ALU_EXEC_R0_ZERO_EN.
// Revision : 1.0
// ============================================================================
module alu_exec_ctrl #(
    parameter int         NUM_REGS = 4,
    parameter logic [7:0] RESET_PC = 8'h00,
    localparam int        RAW      = $clog2(NUM_REGS)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    alu_exec_ctrl_if.master     bus,
    output logic [7:0]          pc,
    output logic                retire,
    output logic                retire_branch,
    input  wire logic [RAW-1:0] dbg_addr,
    output logic [7:0]          dbg_data
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [6:0]     alu_op_q, alu_op_d;
    logic [7:0]     r0_data_q, r0_data_d;
    logic [7:0]     r1_data_q, r1_data_d;
    logic [RAW-1:0] rd_q, rd_d;
    logic [5:0]     br_off_q, br_off_d;
    logic [7:0]     res_q, res_d;
    logic           br_q, br_d;
    logic [7:0]     pc_q, pc_d;
    logic [7:0]     regs_q [NUM_REGS];
    logic [7:0]     regs_d [NUM_REGS];

    logic [6:0]     in_op;
    logic [RAW-1:0] in_rd, in_rs0, in_rs1;
    logic [5:0]     in_off;
    logic           wr_en;

    assign {in_op, in_rd, in_rs0, in_rs1, in_off} = bus.instr;

`ifdef ALU_EXEC_R0_ZERO_EN
    // reg[0] resets to zero and is never written, so every read of it is zero
    assign wr_en = (rd_q != '0);
`else
    assign wr_en = 1'b1;
`endif

    always_comb begin
        state_d         = state_q;
        alu_op_d        = alu_op_q;
        r0_data_d       = r0_data_q;
        r1_data_d       = r1_data_q;
        rd_d            = rd_q;
        br_off_d        = br_off_q;
        res_d           = res_q;
        br_d            = br_q;
        pc_d            = pc_q;
        regs_d          = regs_q;
        bus.instr_ready = 1'b0;
        retire          = 1'b0;
        retire_branch   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    alu_op_d  = in_op;
                    r0_data_d = regs_q[in_rs0];
                    r1_data_d = regs_q[in_rs1];
                    rd_d      = in_rd;
                    br_off_d  = in_off;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = bus.alu_o_data;
                br_d    = bus.alu_b_pcsrc;
                state_d = ST_WB;
            end
            ST_WB: begin
                retire        = 1'b1;
                retire_branch = br_q;
                if (br_q) begin
                    pc_d = pc_q + {{2{br_off_q[5]}}, br_off_q};
                end else begin
                    if (wr_en) begin
                        regs_d[rd_q] = res_q;
                    end
                    pc_d = pc_q + 8'd1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            alu_op_q  <= '0;
            r0_data_q <= '0;
            r1_data_q <= '0;
            rd_q      <= '0;
            br_off_q  <= '0;
            res_q     <= '0;
            br_q      <= 1'b0;
            pc_q      <= RESET_PC;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            alu_op_q  <= alu_op_d;
            r0_data_q <= r0_data_d;
            r1_data_q <= r1_data_d;
            rd_q      <= rd_d;
            br_off_q  <= br_off_d;
            res_q     <= res_d;
            br_q      <= br_d;
            pc_q      <= pc_d;
            regs_q    <= regs_d;
        end
    end

    assign bus.alu_op  = alu_op_q;
    assign bus.r0_data = r0_data_q;
    assign bus.r1_data = r1_data_q;
    assign pc          = pc_q;
    assign dbg_data    = regs_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_ctrl
// Purpose  : Self-checking bench for alu_exec_ctrl with an adder ALU stub
//            and a register/PC reference model.
// Revision : 1.0
// ============================================================================
module tb_alu_exec_ctrl;
    localparam int         NUM_REGS = 4;
    localparam int         RAW      = 2;
    localparam logic [7:0] RESET_PC = 8'h00;
    localparam logic [6:0] OP_ADD   = 7'h01;
    localparam logic [6:0] OP_BEQ   = 7'h40;
    localparam logic [6:0] OP_LDI   = 7'h7E;

    logic           clk = 1'b0;
    logic           rst;
    logic [RAW-1:0] dbg_addr;
    logic [7:0]     dbg_data;
    logic [7:0]     pc;
    logic           retire;
    logic           retire_branch;
    logic [7:0]     ldi_val;

    int n_chk  = 0;
    int n_fail = 0;
    int ret_cnt = 0;
    int acc_cnt = 0;

    logic [7:0] mregs [NUM_REGS];
    logic [7:0] mpc;

    alu_exec_ctrl_if #(.NUM_REGS(NUM_REGS)) bus ();

    alu_exec_ctrl #(.NUM_REGS(NUM_REGS), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .pc            (pc),
        .retire        (retire),
        .retire_branch (retire_branch),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    // ALU stub; the load opcode lets the bench seed registers with constants
    assign bus.alu_o_data  = (bus.alu_op == OP_LDI) ? ldi_val : bus.r0_data + bus.r1_data;
    assign bus.alu_b_pcsrc = (bus.alu_op == OP_BEQ) && (bus.r0_data == bus.r1_data);

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (retire) ret_cnt++;
            if (bus.instr_valid && bus.instr_ready) acc_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mread(input int idx);
`ifdef ALU_EXEC_R0_ZERO_EN
        if (idx == 0) return 8'h00;
`endif
        return mregs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) mregs[i] = 8'h00;
        mpc = RESET_PC;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            dbg_addr = RAW'(i);
            #1;
            chk($sformatf("%s_reg%0d", tag, i), dbg_data, mread(i));
        end
    endtask

    // Call at a negedge while IDLE; returns at the negedge after writeback.
    task automatic issue(input logic [6:0] op, input logic [RAW-1:0] rd, input logic [RAW-1:0] rs0,
                         input logic [RAW-1:0] rs1, input logic [5:0] off, input bit keep);
        logic [7:0] a, b, res;
        bit         br;
        a   = mread(int'(rs0));
        b   = mread(int'(rs1));
        res = (op == OP_LDI) ? ldi_val : a + b;
        br  = (op == OP_BEQ) && (a == b);
        bus.instr       = {op, rd, rs0, rs1, off};
        bus.instr_valid = 1'b1;
        chk("ready_idle", bus.instr_ready, 1);
        @(negedge clk);
        if (!keep) bus.instr_valid = 1'b0;
        chk("exec_op", bus.alu_op, op);
        chk("exec_r0", bus.r0_data, a);
        chk("exec_r1", bus.r1_data, b);
        chk("exec_ready", bus.instr_ready, 0);
        chk("exec_retire", retire, 0);
        @(negedge clk);
        chk("wb_retire", retire, 1);
        chk("wb_retire_branch", retire_branch, br);
        chk("wb_ready", bus.instr_ready, 0);
        if (br) begin
            mpc = mpc + {{2{off[5]}}, off};
        end else begin
            mpc = mpc + 8'd1;
`ifdef ALU_EXEC_R0_ZERO_EN
            if (rd != 0) mregs[rd] = res;
`else
            mregs[rd] = res;
`endif
        end
        @(negedge clk);
        chk("post_pc", pc, mpc);
        chk("post_retire", retire, 0);
        check_regs("post");
    endtask

    task automatic load(input logic [RAW-1:0] rd, input logic [7:0] val);
        ldi_val = val;
        issue(OP_LDI, rd, 0, 0, 6'd0, 1'b0);
    endtask

    task automatic goto_pc(input logic [7:0] target);
        for (int k = 0; k < 20 && mpc !== target; k++) begin
            logic [7:0] diff;
            int         sd;
            diff = target - mpc;
            sd   = int'($signed(diff));
            if (sd > 31)  sd = 31;
            if (sd < -32) sd = -32;
            issue(OP_BEQ, 0, 1, 1, sd[5:0], 1'b0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pc"}, pc, RESET_PC);
        chk({tag, "_ready"}, bus.instr_ready, 1);
        chk({tag, "_alu_op"}, bus.alu_op, 0);
        chk({tag, "_r0"}, bus.r0_data, 0);
        chk({tag, "_r1"}, bus.r1_data, 0);
        chk({tag, "_retire"}, retire, 0);
        chk({tag, "_retire_br"}, retire_branch, 0);
        model_reset();
        check_regs(tag);
    endtask

    task automatic abort_at(input int stage, input logic [RAW-1:0] rd, input logic [7:0] val);
        int rc;
        rc              = ret_cnt;
        ldi_val         = val;
        bus.instr       = {OP_LDI, rd, 2'd0, 2'd0, 6'd0};
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        if (stage == 1) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_state(stage == 1 ? "rst_wb" : "rst_exec");
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_retire", ret_cnt, rc);
    endtask

    initial begin
        logic [6:0] op;
        logic [1:0] r0s, r1s;
        int         ac, rc;

        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        dbg_addr        = '0;
        ldi_val         = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        // Writeback
        load(2'd1, 8'h05);
        load(2'd2, 8'h0A);
        issue(OP_ADD, 2'd3, 2'd1, 2'd2, 6'd0, 1'b0);
        dbg_addr = 2'd3; #1;
        chk("wb_reg3", dbg_data, 8'h0F);

        // Branch taken and not taken
        load(2'd1, 8'h07);
        load(2'd2, 8'h07);
        goto_pc(8'h10);
        issue(OP_BEQ, 2'd3, 2'd1, 2'd2, 6'h3C, 1'b0);
        chk("br_taken_pc", pc, 8'h0C);
        dbg_addr = 2'd3; #1;
        chk("br_taken_reg3", dbg_data, 8'h0F);
        load(2'd2, 8'h08);
        load(2'd3, 8'h00);
        goto_pc(8'h10);
        issue(OP_BEQ, 2'd3, 2'd1, 2'd2, 6'h3C, 1'b0);
        chk("br_not_taken_pc", pc, 8'h11);
        dbg_addr = 2'd3; #1;
        chk("br_not_taken_reg3", dbg_data, 8'h0F);

        // PC wrap both directions
        goto_pc(8'hFF);
        issue(OP_ADD, 2'd3, 2'd1, 2'd1, 6'd0, 1'b0);
        chk("wrap_up_pc", pc, 8'h00);
        goto_pc(8'h02);
        issue(OP_BEQ, 2'd0, 2'd2, 2'd2, 6'h3C, 1'b0);
        chk("wrap_down_pc", pc, 8'hFE);

        // rd aliasing a source register uses the old value
        load(2'd1, 8'h21);
        issue(OP_ADD, 2'd1, 2'd1, 2'd1, 6'd0, 1'b0);

        // Back-to-back with valid held high
        ac = acc_cnt;
        rc = ret_cnt;
        load(2'd1, 8'h03);
        for (int i = 0; i < 10; i++) issue(OP_ADD, 2'd1, 2'd1, 2'd2, 6'd0, (i < 9));
        chk("hs_accepts", acc_cnt - ac, 11);
        chk("hs_retires", ret_cnt - rc, 11);

        // Randomised instruction mix
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       op = OP_ADD;
                1:       op = OP_BEQ;
                2:       op = OP_LDI;
                default: op = 7'($urandom_range(0, 127));
            endcase
            r0s     = 2'($urandom_range(0, 3));
            r1s     = ($urandom_range(0, 1) == 1) ? r0s : 2'($urandom_range(0, 3));
            ldi_val = 8'($urandom_range(0, 255));
            issue(op, 2'($urandom_range(0, 3)), r0s, r1s, 6'($urandom_range(0, 63)), 1'b0);
        end

        // Mid-run reset, then reset during EXEC and during WB
        rst = 1'b1;
        #1;
        check_reset_state("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        load(2'd1, 8'h11);
        abort_at(0, 2'd2, 8'h5A);
        load(2'd1, 8'h22);
        abort_at(1, 2'd2, 8'h5A);

        // Write to rd=0 (dropped when reg[0] is hardwired)
        load(2'd0, 8'h0F);
        dbg_addr = 2'd0; #1;
`ifdef ALU_EXEC_R0_ZERO_EN
        chk("r0_zero", dbg_data, 8'h00);
`else
        chk("r0_write", dbg_data, 8'h0F);
`endif
        chk("r0_pc", pc, RESET_PC + 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
